// File: rtl/sa_input_requester_if.sv
// Switch-allocation bundle for one input port: VC buffer heads,
// allocator request/grant row and the registered switch-traversal flit.
interface sa_input_requester_if #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_VCS    = 4,
  parameter int FLIT_WIDTH = 32
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int VW = $clog2(NUM_VCS);

  logic [NUM_VCS-1:0]                 vc_valid;
  logic [NUM_VCS-1:0]                 vc_tail;
  logic [NUM_VCS-1:0]                 vc_credit_ok;
  logic [NUM_VCS-1:0][PW-1:0]         vc_out_port;
  logic [NUM_VCS-1:0][FLIT_WIDTH-1:0] vc_flit;
  logic [NUM_PORTS-1:0]               port_request;
  logic [NUM_PORTS-1:0]               port_grant;
  logic [NUM_VCS-1:0]                 vc_pop;
  logic                               st_valid;
  logic [FLIT_WIDTH-1:0]              st_flit;
  logic [NUM_PORTS-1:0]               st_out_port;
  logic [VW-1:0]                      st_vc;

  modport master (
    output vc_valid, vc_tail, vc_credit_ok,
    output vc_out_port, vc_flit, port_grant,
    input  port_request, vc_pop,
    input  st_valid, st_flit, st_out_port, st_vc
  );

  modport slave (
    input  vc_valid, vc_tail, vc_credit_ok,
    input  vc_out_port, vc_flit, port_grant,
    output port_request, vc_pop,
    output st_valid, st_flit, st_out_port, st_vc
  );
endinterface

// File: rtl/sa_input_requester.sv
// Per-input-port switch-allocation requester with wormhole VC lock.
// Optional SA_REQ_STATS_EN adds saturating grant/stall counters.
module sa_input_requester #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_VCS    = 4,
  parameter int FLIT_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  sa_input_requester_if.slave sa
`ifdef SA_REQ_STATS_EN
  ,
  output logic [31:0] stat_grants,
  output logic [31:0] stat_stalls
`endif
);
  localparam int VW = $clog2(NUM_VCS);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } state_e;

  state_e state_q, state_d;
  logic [VW-1:0] lock_vc_q, lock_vc_d;
  logic [VW-1:0] rr_q, rr_d;
  logic [VW-1:0] sel_vc, cur_vc, nxt_vc;
  logic [NUM_VCS-1:0] elig;
  logic [NUM_VCS-1:0] pop;
  logic [NUM_PORTS-1:0] req;
  logic found, hit;

  logic                  st_valid_q;
  logic [FLIT_WIDTH-1:0] st_flit_q;
  logic [NUM_PORTS-1:0]  st_out_q;
  logic [VW-1:0]         st_vc_q;

  assign elig = sa.vc_valid & sa.vc_credit_ok;

  // First eligible VC at or after the round-robin pointer
  always_comb begin
    int idx;
    sel_vc = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_VCS; i++) begin
      idx = (int'(rr_q) + i) % NUM_VCS;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        sel_vc = VW'(idx);
      end
    end
  end

  assign cur_vc = (state_q == LOCKED) ? lock_vc_q : sel_vc;

  assign nxt_vc = (cur_vc == VW'(NUM_VCS - 1)) ?
                  '0 : cur_vc + 1'b1;

  // Request row is held low while reset is asserted
  always_comb begin
    req = '0;
    if (reset && elig[cur_vc])
      req[sa.vc_out_port[cur_vc]] = 1'b1;
  end

  assign hit = |(sa.port_grant & req);

  always_comb begin
    pop = '0;
    if (hit)
      pop[cur_vc] = 1'b1;
  end

  assign sa.port_request = req;
  assign sa.vc_pop       = pop;

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_d      = rr_q;
    unique case (state_q)
      UNLOCKED: begin
        if (hit) begin
          if (sa.vc_tail[cur_vc]) begin
            rr_d = nxt_vc;
          end else begin
            state_d   = LOCKED;
            lock_vc_d = cur_vc;
          end
        end
      end
      LOCKED: begin
        if (hit && sa.vc_tail[cur_vc]) begin
          state_d = UNLOCKED;
          rr_d    = nxt_vc;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= UNLOCKED;
      lock_vc_q <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_q      <= rr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_valid_q <= 1'b0;
      st_flit_q  <= '0;
      st_out_q   <= '0;
      st_vc_q    <= '0;
    end else begin
      st_valid_q <= hit;
      if (hit) begin
        st_flit_q <= sa.vc_flit[cur_vc];
        st_out_q  <= req;
        st_vc_q   <= cur_vc;
      end
    end
  end

  assign sa.st_valid    = st_valid_q;
  assign sa.st_flit     = st_flit_q;
  assign sa.st_out_port = st_out_q;
  assign sa.st_vc       = st_vc_q;

`ifdef SA_REQ_STATS_EN
  logic [31:0] grants_q, stalls_q;
  logic        stall;

  assign stall = (|req) && !hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (hit && grants_q != 32'hFFFF_FFFF)
        grants_q <= grants_q + 32'd1;
      if (stall && stalls_q != 32'hFFFF_FFFF)
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`endif

endmodule
